// File: rtl/hex_keypad_scanner.sv
`default_nettype none
// ============================================================================
// hex_keypad_scanner : 4x4 matrix keypad scanner with debounce and hex encode
// Revision: 1.0
// ============================================================================
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 16000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [3:0]    row_s1;
  logic [3:0]    rs;
  logic [CW-1:0] slot_cnt;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_next;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [3:0]    low;
  logic          single;
  logic          sample;
  logic [1:0]    cur_row;

  function automatic logic [1:0] row_enc(input logic [3:0] l);
    case (l)
      4'b0001: row_enc = 2'd0;
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      default: row_enc = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] code_lut(input logic [3:0] idx);
    case (idx)
      4'h0: code_lut = 4'h1;  4'h1: code_lut = 4'h2;
      4'h2: code_lut = 4'h3;  4'h3: code_lut = 4'hA;
      4'h4: code_lut = 4'h4;  4'h5: code_lut = 4'h5;
      4'h6: code_lut = 4'h6;  4'h7: code_lut = 4'hB;
      4'h8: code_lut = 4'h7;  4'h9: code_lut = 4'h8;
      4'hA: code_lut = 4'h9;  4'hB: code_lut = 4'hC;
      4'hC: code_lut = 4'hE;  4'hD: code_lut = 4'h0;
      4'hE: code_lut = 4'hF;  default: code_lut = 4'hD;
    endcase
  endfunction

  // Reset asserts asynchronously but releases two clocks after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      rs     <= 4'hF;
    end else begin
      row_s1 <= row;
      rs     <= row_s1;
    end
  end

  assign low      = ~rs;
  assign single   = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign cur_row  = row_enc(low);
  assign sample   = (slot_cnt == SLOT_LAST);
  assign deb_next = deb_cnt + DEB_ONE;
  assign col      = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      slot_cnt  <= '0;
      deb_cnt   <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      slot_cnt  <= sample ? '0 : slot_cnt + CW'(1);
      if (sample) begin
        case (state)
          SCAN: begin
            if (single) begin
              row_idx <= cur_row;
              deb_cnt <= DEB_ONE;
              if (DEB_LAST == DEB_ONE) begin
                key_code  <= code_lut({cur_row, col_idx});
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HELD;
              end else begin
                state <= PRESS;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
          PRESS: begin
            if (single && (cur_row == row_idx)) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_LAST) begin
                key_code  <= code_lut({row_idx, col_idx});
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HELD;
              end
            end else begin
              deb_cnt <= '0;
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end
          HELD: begin
            if (!single) begin
              deb_cnt <= DEB_ONE;
              if (DEB_LAST == DEB_ONE) begin
                key_down <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                state    <= SCAN;
              end else begin
                state <= RELEASE;
              end
            end
          end
          default: begin
            // Any single row, latched or not, means the key is still considered held.
            if (!single) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_LAST) begin
                deb_cnt  <= '0;
                key_down <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                state    <= SCAN;
              end
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
